// File: rtl/alu_div_pkg.sv
// Shared definitions for the unsigned divider: FSM states, counter sizing
// and the quotient returned on a divide by zero.
package alu_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH_DEFAULT = 24;
    localparam int DIV_WIDTH_MAX     = 64;

    // Sliced down to the instance width by the divider.
    localparam logic [DIV_WIDTH_MAX-1:0] DIV0_QUOT = '1;

    function automatic int div_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shift in the next dividend bit, then
// subtract the divisor if it fits.
module divider_step #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] p;
    logic [WIDTH:0] diff;

    // Full-width partial remainder keeps the WIDTH+1 bit compare exact even
    // when the divisor has its top bit set.  With rem < divisor on entry,
    // a borrow out of the subtract is exactly "p < divisor".
    always_comb begin
        p        = {rem, dividend_msb};
        diff     = p - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        next_rem = q_bit ? diff[WIDTH-1:0] : p[WIDTH-1:0];
    end

endmodule

// File: rtl/divider_unsigned.sv
// Sequential radix-2 restoring unsigned divider, one quotient bit per clock.
// Optional build macro DIVIDER_EARLY_OUT_EN: finish in one cycle when rs1 < rs2.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// CALC  | iterating (or one-cycle finish for divide-by-zero / early out)
// DONE  | valid pulse; start here begins the next operation immediately
module divider_unsigned
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             valid,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int               CW         = div_cnt_width(WIDTH);
    localparam logic [CW-1:0]    LAST_STEP  = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] QUOT_DIV0  = DIV0_QUOT[WIDTH-1:0];

    div_state_e       state;
    div_state_e       state_nxt;

    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [CW-1:0]    count;
    logic             dz_q;
    logic             early_q;
    logic             early_det;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] remainder_q;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic             accept;
    logic             short_op;
    logic             finish_calc;

    divider_step #(.WIDTH(WIDTH)) u_step (
        .rem          (rem),
        .dividend_msb (dvd[WIDTH-1]),
        .divisor      (dvs),
        .next_rem     (step_rem),
        .q_bit        (step_q)
    );

`ifdef DIVIDER_EARLY_OUT_EN
    assign early_det = (rs2 != '0) && (rs1 < rs2);
`else
    assign early_det = 1'b0;
`endif

    assign accept      = start && (state != CALC);
    assign short_op    = dz_q || early_q;
    assign finish_calc = (state == CALC) && (short_op || (count == LAST_STEP));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start ? CALC : IDLE;
            CALC:       if (finish_calc) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        valid       = 1'b0;
        div_by_zero = 1'b0;
        case (state)
            CALC: busy = 1'b1;
            DONE: begin
                valid       = 1'b1;
                div_by_zero = dz_q;
            end
            default: ;
        endcase
    end

    // Datapath: operands are captured only on an accepted start, so start
    // held high through CALC cannot disturb an operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            quo         <= '0;
            count       <= '0;
            dz_q        <= 1'b0;
            early_q     <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
        end else if (accept) begin
            dvd     <= rs1;
            dvs     <= rs2;
            rem     <= '0;
            quo     <= '0;
            count   <= '0;
            dz_q    <= (rs2 == '0);
            early_q <= early_det;
        end else if (state == CALC) begin
            if (dz_q) begin
                result_q    <= QUOT_DIV0;
                remainder_q <= dvd;
            end else if (early_q) begin
                result_q    <= '0;
                remainder_q <= dvd;
            end else begin
                rem   <= step_rem;
                dvd   <= {dvd[WIDTH-2:0], 1'b0};
                quo   <= {quo[WIDTH-2:0], step_q};
                count <= count + CW'(1);
                if (count == LAST_STEP) begin
                    result_q    <= {quo[WIDTH-2:0], step_q};
                    remainder_q <= step_rem;
                end
            end
        end
    end

    assign result    = result_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_divider_unsigned.sv
// Self-checking bench for divider_unsigned: directed cases, handshake,
// reset abort and randomized operands against an arithmetic model.
module tb_divider_unsigned;

    localparam int W = 24;
`ifdef DIVIDER_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
    logic         start;
    logic [W-1:0] result;
    logic [W-1:0] remainder;
    logic         valid;
    logic         busy;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    divider_unsigned #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .rs1         (rs1),
        .rs2         (rs2),
        .start       (start),
        .result      (result),
        .remainder   (remainder),
        .valid       (valid),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic plus the latency rules.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eq, output logic [W-1:0] er,
                         output logic edz, output int elat);
        if (b == 0) begin
            eq = {W{1'b1}}; er = a; edz = 1'b1; elat = 1;
        end else begin
            eq = a / b; er = a % b; edz = 1'b0;
            elat = (EARLY && (a < b)) ? 1 : W;
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [W-1:0] eq, er;
        logic         edz;
        int           elat, lat;
        model(a, b, eq, er, edz, elat);
        @(negedge clk);
        rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rs1 = W'($urandom); rs2 = W'($urandom);
        check_val({tag, "_busy"}, 64'(busy), 64'd1);
        wait_valid(lat);
        check_val({tag, "_lat"}, 64'(lat), 64'(elat));
        check_val({tag, "_q"}, 64'(result), 64'(eq));
        check_val({tag, "_r"}, 64'(remainder), 64'(er));
        check_val({tag, "_dz"}, 64'(div_by_zero), 64'(edz));
        @(posedge clk); #1;
        check_val({tag, "_pulse"}, 64'(valid), 64'd0);
        check_val({tag, "_hold"}, 64'(result), 64'(eq));
    endtask

    initial begin
        logic [W-1:0] a, b, eq, er;
        logic         edz, seen;
        int           elat, lat;

        rst = 1'b1; start = 1'b0; rs1 = '0; rs2 = '0;
        #1;
        check_val("rst_q", 64'(result), 64'd0);
        check_val("rst_r", 64'(remainder), 64'd0);
        check_val("rst_valid", 64'(valid), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_dz", 64'(div_by_zero), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(24'h04EDC2, 24'h000456, "exact");
        run_op(24'h000064, 24'h000007, "rem");
        run_op(24'hFFFFFF, 24'h000001, "max");
        run_op(24'h00ABCD, 24'h000000, "div0");
        run_op(24'h000005, 24'h000009, "small");
        run_op(24'h123456, 24'hFFFFFF, "bigdiv");
        run_op(24'hFFFFFF, 24'h800001, "topbit");

        // start held through CALC with changing operands; second op starts from DONE
        @(negedge clk);
        rs1 = 24'h04EDC2; rs2 = 24'h000456; start = 1'b1;
        @(posedge clk); #1;
        rs1 = 24'h000064; rs2 = 24'h000007;
        check_val("hs_busy", 64'(busy), 64'd1);
        wait_valid(lat);
        check_val("hs1_lat", 64'(lat), 64'(W));
        check_val("hs1_q", 64'(result), 64'h123);
        check_val("hs1_r", 64'(remainder), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check_val("hs2_busy", 64'(busy), 64'd1);
        check_val("hs2_novalid", 64'(valid), 64'd0);
        wait_valid(lat);
        check_val("hs2_lat", 64'(lat), 64'(W));
        check_val("hs2_q", 64'(result), 64'h00000E);
        check_val("hs2_r", 64'(remainder), 64'h000002);

        // reset in the middle of CALC
        @(negedge clk);
        rs1 = 24'hABCDEF; rs2 = 24'h000003; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_val("abort_q", 64'(result), 64'd0);
        check_val("abort_r", 64'(remainder), 64'd0);
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_valid", 64'(valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (valid) seen = 1'b1;
        end
        check_val("abort_no_valid", 64'(seen), 64'd0);
        run_op(24'h000100, 24'h000010, "recover");

        for (int i = 0; i < 50; i++) begin
            case ($urandom_range(0, 4))
                0: begin a = W'($urandom); b = '0; end
                1: begin a = W'($urandom); b = W'($urandom_range(1, 15)); end
                2: begin b = W'($urandom) | 24'h1; a = W'($urandom_range(0, 32'(b) - 1)); end
                default: begin a = W'($urandom); b = W'($urandom); end
            endcase
            run_op(a, b, $sformatf("rnd%0d", i));
        end

        model(24'h0, 24'h0, eq, er, edz, elat);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
